// File: rtl/polar_sc_decoder_if.sv
// Frame handshake bundle between the LLR source, the SC decoder and the bit sink.
interface polar_sc_decoder_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8
);
  logic [N*WIDTH-1:0] llr_in;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       u_hat;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  // Source of frames / sink of decisions
  modport master (
    output llr_in, in_valid, out_ready,
    input  in_ready, u_hat, out_valid, busy
  );

  // Decoder side
  modport slave (
    input  llr_in, in_valid, out_ready,
    output in_ready, u_hat, out_valid, busy
  );
endinterface

// File: rtl/polar_sc_decoder.sv
// Successive-cancellation polar decoder: one tree node (f or g) per cycle,
// min-sum arithmetic, depth-first schedule, one frame in flight.
module polar_sc_decoder #(
  parameter int unsigned    N           = 8,
  parameter int unsigned    WIDTH       = 8,
  parameter logic [N-1:0]   FROZEN_MASK = N'(8'h17)
) (
  input  logic               clk,
  input  logic               rst,
  polar_sc_decoder_if.slave  bus
);

  localparam int unsigned NLOG      = $clog2(N);
  localparam int unsigned HALF      = N / 2;
  localparam int unsigned IW        = NLOG;
  localparam int unsigned LW        = $clog2(NLOG + 1);
  localparam int unsigned SW        = $clog2(2 * N);
  localparam int unsigned LAST_STEP = 2 * N - 3;

  localparam logic signed [WIDTH-1:0] LLR_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] LLR_NMAX    = -LLR_MAX;
  localparam logic        [WIDTH-1:0] LLR_MIN_RAW = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // LLR storage: level k holds the 2^k LLRs of the node currently open at that size
  logic signed [WIDTH-1:0] r_llr [1:NLOG][0:N-1];
  // Partial sums: level m holds the re-encoded bits of the last finished left child of size 2^m
  logic [N-1:0]            r_ps  [0:NLOG-1];

  logic [SW-1:0]  r_step;
  logic [IW-1:0]  r_leaf;
  logic [LW-1:0]  r_lvl;
  logic           r_is_g;
  logic [N-1:0]   r_bits;

  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_busy;
  logic [N-1:0]   r_u_hat;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_in_ready_nxt;
  logic                    w_out_valid_nxt;
  logic                    w_busy_nxt;
  logic signed [WIDTH-1:0] w_a   [0:HALF-1];
  logic signed [WIDTH-1:0] w_b   [0:HALF-1];
  logic signed [WIDTH-1:0] w_res [0:HALF-1];
  logic [HALF-1:0]         w_s;
  logic                    w_leaf_dec;
  logic                    w_u;
  logic [N-1:0]            w_bits_nxt;
  logic [N-1:0]            w_vec [0:NLOG-1];
  logic [NLOG-1:0]         w_ps_we;
  logic                    w_run;
  logic [IW-1:0]           w_leaf_inc;
  logic [LW-1:0]           w_ctz;
  logic                    w_found;
  logic [LW-1:0]           w_g_lvl;

  // Min-sum check-node update; zero counts as positive
  function automatic logic signed [WIDTH-1:0] f_minsum(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] abs_a;
    logic signed [WIDTH-1:0] abs_b;
    logic signed [WIDTH-1:0] m;
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
    m     = (abs_a < abs_b) ? abs_a : abs_b;
    return (a[WIDTH-1] ^ b[WIDTH-1]) ? -m : m;
  endfunction

  // Variable-node update with one guard bit, saturated back to the symmetric range
  function automatic logic signed [WIDTH-1:0] g_sat(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic                    s
  );
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    logic signed [WIDTH:0] sum;
    ea  = (WIDTH+1)'(a);
    eb  = (WIDTH+1)'(b);
    sum = s ? (eb - ea) : (eb + ea);
    if (sum > (WIDTH+1)'(LLR_MAX)) begin
      return LLR_MAX;
    end else if (sum < (WIDTH+1)'(LLR_NMAX)) begin
      return LLR_NMAX;
    end
    return WIDTH'(sum);
  endfunction

  // Fold the asymmetric most-negative code onto the symmetric range
  function automatic logic signed [WIDTH-1:0] clamp_llr(input logic [WIDTH-1:0] x);
    return (x == LLR_MIN_RAW) ? LLR_NMAX : $signed(x);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid)                w_state_nxt = S_DECODE;
      S_DECODE: if (r_step == SW'(LAST_STEP))    w_state_nxt = S_DONE;
      S_DONE:   if (bus.out_ready)               w_state_nxt = S_IDLE;
      default:                                   w_state_nxt = S_IDLE;
    endcase
  end

  // Output / strobe decode; handshake outputs follow the upcoming state
  always_comb begin
    w_accept        = 1'b0;
    w_last          = 1'b0;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_accept        = (r_state == S_IDLE) && bus.in_valid;
    w_last          = (r_state == S_DECODE) && (r_step == SW'(LAST_STEP));
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
    w_busy_nxt      = (w_state_nxt == S_DECODE);
  end

  // Registered handshake outputs and decoded word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_u_hat     <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      if (w_accept) begin
        r_u_hat <= '0;
      end else if (w_last) begin
        r_u_hat <= w_bits_nxt;
      end
    end
  end

  // Operand fetch from the level currently being split
  always_comb begin
    for (int j = 0; j < int'(HALF); j++) begin
      w_a[j] = '0;
      w_b[j] = '0;
    end
    w_s = '0;
    for (int k = 1; k <= int'(NLOG); k++) begin
      if (r_lvl == LW'(k)) begin
        for (int j = 0; j < (1 << (k - 1)); j++) begin
          w_a[j] = r_llr[k][j];
          w_b[j] = r_llr[k][j + (1 << (k - 1))];
          w_s[j] = r_ps[k-1][j];
        end
      end
    end
  end

  // Node arithmetic, all elements in parallel
  always_comb begin
    for (int j = 0; j < int'(HALF); j++) begin
      w_res[j] = r_is_g ? g_sat(w_a[j], w_b[j], w_s[j]) : f_minsum(w_a[j], w_b[j]);
    end
  end

  // Leaf decision, partial-sum butterfly and traversal bookkeeping
  always_comb begin
    w_leaf_dec = (r_state == S_DECODE) && (r_lvl == LW'(1));
    w_u        = ~FROZEN_MASK[r_leaf] & w_res[0][WIDTH-1];
    w_bits_nxt = r_bits | (N'(w_u) << r_leaf);

    for (int m = 0; m < int'(NLOG); m++) begin
      w_vec[m] = '0;
    end
    w_vec[0] = N'(w_u);
    for (int m = 0; m < int'(NLOG) - 1; m++) begin
      for (int j = 0; j < (1 << m); j++) begin
        w_vec[m+1][j]            = r_ps[m][j] ^ w_vec[m][j];
        w_vec[m+1][j + (1 << m)] = w_vec[m][j];
      end
    end

    // A finished subtree of size 2^m is stored where the leaf index has its lowest zero bit
    w_ps_we = '0;
    w_run   = w_leaf_dec;
    for (int m = 0; m < int'(NLOG); m++) begin
      w_ps_we[m] = w_run & ~r_leaf[m];
      w_run      = w_run & r_leaf[m];
    end

    // Next leaf restarts at the level of the deepest shared ancestor, with a g
    w_leaf_inc = r_leaf + IW'(1);
    w_ctz      = '0;
    w_found    = 1'b0;
    for (int b = 0; b < int'(IW); b++) begin
      if (!w_found) begin
        if (w_leaf_inc[b]) begin
          w_found = 1'b1;
        end else begin
          w_ctz = w_ctz + LW'(1);
        end
      end
    end
    w_g_lvl = w_ctz + LW'(1);
  end

  // Schedule counters, decided bits and partial sums
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_step <= '0;
      r_leaf <= '0;
      r_lvl  <= LW'(NLOG);
      r_is_g <= 1'b0;
      r_bits <= '0;
      for (int m = 0; m < int'(NLOG); m++) begin
        r_ps[m] <= '0;
      end
    end else if (r_state == S_DECODE) begin
      r_step <= r_step + SW'(1);
      if (w_leaf_dec) begin
        r_bits <= w_bits_nxt;
        r_leaf <= w_leaf_inc;
        r_lvl  <= w_g_lvl;
        r_is_g <= 1'b1;
        for (int m = 0; m < int'(NLOG); m++) begin
          if (w_ps_we[m]) begin
            r_ps[m] <= w_vec[m];
          end
        end
      end else begin
        r_lvl  <= r_lvl - LW'(1);
        r_is_g <= 1'b0;
      end
    end
  end

  // LLR storage: channel capture on accept, child LLRs written during decode
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < int'(N); i++) begin
        r_llr[NLOG][i] <= clamp_llr(bus.llr_in[i*WIDTH +: WIDTH]);
      end
    end else if (r_state == S_DECODE) begin
      for (int k = 2; k <= int'(NLOG); k++) begin
        if (r_lvl == LW'(k)) begin
          for (int j = 0; j < (1 << (k - 1)); j++) begin
            r_llr[k-1][j] <= w_res[j];
          end
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.u_hat     = r_u_hat;

endmodule
